// File: rtl/ldpc_vnu_serial.sv
// Serial min-sum LDPC variable node: accumulates LLR + sum(R), then streams
// saturated extrinsic messages Q_i = total - R_i and the hard decision.
module ldpc_vnu_serial #(
  parameter int W      = 32,
  parameter int DEGREE = 3,
  parameter int AW     = W + 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic signed [W-1:0]         llr_in,
  input  logic                        r_valid,
  input  logic signed [W-1:0]         r_in,
  output logic                        r_ready,
  output logic                        q_valid,
  output logic signed [W-1:0]         q_out,
  output logic [$clog2(DEGREE)-1:0]   q_idx,
  input  logic                        q_ready,
  output logic signed [W-1:0]         total_llr,
  output logic                        hard_dec,
  output logic                        busy,
  output logic                        done
);

  localparam int IW = $clog2(DEGREE);
  localparam logic [IW-1:0] IDX_ZERO = {IW{1'b0}};
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DEGREE - 1);
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, EMIT = 2'd2, FIN = 2'd3} state_e;

  function automatic logic signed [AW-1:0] sext(input logic signed [W-1:0] x);
    return {{(AW-W){x[W-1]}}, x};
  endfunction

  // Clamp an accumulator-width value into the W-bit message range.
  function automatic logic signed [W-1:0] sat(input logic signed [AW-1:0] x);
    logic signed [W-1:0] y;
    if (x > SAT_MAX) begin
      y = SAT_MAX[W-1:0];
    end else if (x < SAT_MIN) begin
      y = SAT_MIN[W-1:0];
    end else begin
      y = x[W-1:0];
    end
    return y;
  endfunction

  state_e                state_q, state_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic signed [W-1:0]   rbuf_q [DEGREE];
  logic signed [W-1:0]   rbuf_d [DEGREE];
  logic signed [W-1:0]   total_q, total_d;
  logic                  hard_q, hard_d;
  logic signed [AW-1:0]  sum_s;
  logic signed [AW-1:0]  diff_s;
  logic                  idx_last_s;

  assign sum_s      = acc_q + sext(r_in);
  assign diff_s     = acc_q - sext(rbuf_q[idx_q]);
  assign idx_last_s = (idx_q == IDX_LAST);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    rbuf_d  = rbuf_q;
    total_d = total_q;
    hard_d  = hard_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = sext(llr_in);
          idx_d   = IDX_ZERO;
          state_d = ACCUM;
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (r_valid) begin
          rbuf_d[idx_q] = r_in;
          acc_d         = sum_s;
          // hard decision takes the unsaturated sign so overflowed totals stay correct
          if (idx_last_s) begin
            state_d = EMIT;
            idx_d   = IDX_ZERO;
            total_d = sat(sum_s);
            hard_d  = sum_s[AW-1];
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end else begin
          state_d = ACCUM;
        end
      end
      EMIT: begin
        if (q_ready) begin
          if (idx_last_s) begin
            state_d = FIN;
            idx_d   = IDX_ZERO;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end else begin
          state_d = EMIT;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= {AW{1'b0}};
      idx_q   <= IDX_ZERO;
      total_q <= {W{1'b0}};
      hard_q  <= 1'b0;
      for (int i = 0; i < DEGREE; i++) begin
        rbuf_q[i] <= {W{1'b0}};
      end
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      total_q <= total_d;
      hard_q  <= hard_d;
      rbuf_q  <= rbuf_d;
    end
  end

  always_comb begin
    r_ready   = (state_q == ACCUM);
    q_valid   = (state_q == EMIT);
    busy      = (state_q != IDLE);
    done      = (state_q == FIN);
    total_llr = total_q;
    hard_dec  = hard_q;
    if (state_q == EMIT) begin
      q_out = sat(diff_s);
      q_idx = idx_q;
    end else begin
      q_out = {W{1'b0}};
      q_idx = IDX_ZERO;
    end
  end

endmodule

// File: tb/tb_ldpc_vnu_serial.sv
// Directed table-driven bench for ldpc_vnu_serial (W=32, DEGREE=3), with
// hand-written reset-abort and back-to-back sequences.
module tb_ldpc_vnu_serial;

  localparam int W = 32;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic signed [W-1:0] llr_in;
  logic                r_valid;
  logic signed [W-1:0] r_in;
  logic                r_ready;
  logic                q_valid;
  logic signed [W-1:0] q_out;
  logic [1:0]          q_idx;
  logic                q_ready;
  logic signed [W-1:0] total_llr;
  logic                hard_dec;
  logic                busy;
  logic                done;

  ldpc_vnu_serial #(.W(W), .DEGREE(3), .AW(W + 4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .llr_in(llr_in),
    .r_valid(r_valid), .r_in(r_in), .r_ready(r_ready),
    .q_valid(q_valid), .q_out(q_out), .q_idx(q_idx), .q_ready(q_ready),
    .total_llr(total_llr), .hard_dec(hard_dec), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]      llr;
    logic [2:0][31:0] r;
    logic [31:0]      tot;
    logic             hard;
    logic [2:0][31:0] q;
    int               gap;
    int               stall_idx;
    int               stall;
    bit               ctl;
  } vec_t;

  vec_t        tbl [8];
  int          n_chk;
  int          n_bad;
  logic [31:0] prev_total;
  logic        prev_hard;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_node(input vec_t v);
    step();
    chk("idle_busy_done", {30'd0, busy, done}, 32'd0);
    chk("total_hold_idle", total_llr, prev_total);
    start  = 1'b1;
    llr_in = v.llr;
    step();
    start = 1'b0;
    chk("r_ready_after_start", {31'd0, r_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        for (int g = 0; g < v.gap; g++) begin
          r_valid = 1'b0;
          step();
          chk("r_ready_gap", {31'd0, r_ready}, 32'd1);
        end
      end
      if (i == 2) begin
        chk("total_hold_accum", total_llr, prev_total);
        chk("hard_hold_accum", {31'd0, hard_dec}, {31'd0, prev_hard});
      end
      if (v.ctl && i == 1) begin
        start  = 1'b1;
        llr_in = 32'h0001_2345;
      end
      r_valid = 1'b1;
      r_in    = v.r[i];
      step();
      start = 1'b0;
    end
    r_valid = 1'b0;
    chk("q_valid_after_last_r", {31'd0, q_valid}, 32'd1);
    chk("total_llr", total_llr, v.tot);
    chk("hard_dec", {31'd0, hard_dec}, {31'd0, v.hard});
    prev_total = v.tot;
    prev_hard  = v.hard;
    for (int i = 0; i < 3; i++) begin
      if (i == v.stall_idx) begin
        for (int s = 0; s < v.stall; s++) begin
          q_ready = 1'b0;
          chk("q_valid_stall", {31'd0, q_valid}, 32'd1);
          chk("q_idx_stall", {30'd0, q_idx}, i);
          chk("q_out_stall", q_out, v.q[i]);
          step();
        end
      end
      chk("q_valid", {31'd0, q_valid}, 32'd1);
      chk("q_idx", {30'd0, q_idx}, i);
      chk("q_out", q_out, v.q[i]);
      if (v.ctl && i == 0) begin
        start  = 1'b1;
        llr_in = 32'h0006_7890;
      end
      q_ready = 1'b1;
      step();
      start = 1'b0;
    end
    q_ready = 1'b0;
    chk("done_pulse", {29'd0, done, busy, q_valid}, {29'd0, 3'b110});
  endtask

  initial begin
    n_chk      = 0;
    n_bad      = 0;
    prev_total = 32'd0;
    prev_hard  = 1'b0;
    rst_n      = 1'b0;
    start      = 1'b0;
    llr_in     = 32'd0;
    r_valid    = 1'b0;
    r_in       = 32'd0;
    q_ready    = 1'b0;

    //                llr           r2           r1           r0           tot          hard  q2           q1           q0           gap stall_idx stall ctl
    tbl[0] = '{32'd5,        {32'd2,        -32'sd7,      32'd3},        32'd3,        1'b0, {32'd1,        32'd10,       32'd0},        0, -1, 0, 1'b0};
    tbl[1] = '{-32'sd4,      {-32'sd1,      -32'sd1,      -32'sd1},      -32'sd7,      1'b1, {-32'sd6,      -32'sd6,      -32'sd6},      0, -1, 0, 1'b0};
    tbl[2] = '{32'h7FFFFFFF, {32'd0,        32'd1,        32'h7FFFFFFF}, 32'h7FFFFFFF, 1'b0, {32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF}, 0, -1, 0, 1'b0};
    tbl[3] = '{32'h80000000, {32'd0,        -32'sd1,      32'h80000000}, 32'h80000000, 1'b1, {32'h80000000, 32'h80000000, 32'h80000000}, 0, -1, 0, 1'b0};
    tbl[4] = '{32'd5,        {32'd2,        -32'sd7,      32'd3},        32'd3,        1'b0, {32'd1,        32'd10,       32'd0},        2, -1, 0, 1'b0};
    tbl[5] = '{32'd5,        {32'd2,        -32'sd7,      32'd3},        32'd3,        1'b0, {32'd1,        32'd10,       32'd0},        0,  1, 4, 1'b0};
    tbl[6] = '{32'd5,        {32'd2,        -32'sd7,      32'd3},        32'd3,        1'b0, {32'd1,        32'd10,       32'd0},        0, -1, 0, 1'b1};
    tbl[7] = '{32'd0,        {32'd0,        -32'sd1,      32'd1},        32'd0,        1'b0, {32'd0,        32'd1,        -32'sd1},      1,  2, 2, 1'b0};

    #1;
    chk("reset_outputs", {24'd0, r_ready, q_valid, q_idx, hard_dec, busy, done, 1'b0}, 32'd0);
    chk("reset_q_out", q_out, 32'd0);
    chk("reset_total", total_llr, 32'd0);
    repeat (2) step();
    rst_n = 1'b1;

    for (int n = 0; n < 8; n++) begin
      run_node(tbl[n]);
    end

    // abort a node with reset after two R beats
    step();
    start  = 1'b1;
    llr_in = 32'd5;
    step();
    start   = 1'b0;
    r_valid = 1'b1;
    r_in    = 32'd3;
    step();
    r_in = -32'sd7;
    step();
    r_valid = 1'b0;
    chk("pre_abort_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {24'd0, r_ready, q_valid, q_idx, hard_dec, busy, done, 1'b0}, 32'd0);
    chk("abort_q_out", q_out, 32'd0);
    step();
    chk("abort_total", total_llr, 32'd0);
    rst_n      = 1'b1;
    prev_total = 32'd0;
    prev_hard  = 1'b0;

    run_node(tbl[0]);
    run_node(tbl[1]);
    step();
    chk("final_idle", {30'd0, busy, done}, 32'd0);
    chk("final_total_hold", total_llr, prev_total);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
